// File: rtl/pattern_window_detector.sv
// pattern_window_detector: multi-window white-pattern detector for the camera path.
// NUM_WIN search windows each sweep their own horizontal segment, one STEP per frame.
// A window detects after LINES_MIN consecutive lines with >= RUN_MIN white pixels;
// the detection is reported as a margin-padded, clamped bounding box.
// Optional feature macro: VERIF_HOLD_EN (timed release of the lock after HOLD_FRAMES).
module pattern_window_detector #(
  parameter int unsigned NUM_WIN     = 2,
  parameter int unsigned PIX_W       = 10,
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned WIN_W       = 250,
  parameter int unsigned STEP        = 10,
  parameter int unsigned RUN_MIN     = 180,
  parameter int unsigned LINES_MIN   = 55,
  parameter int unsigned MARGIN_X    = 15,
  parameter int unsigned MARGIN_Y    = 10,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             padrao,
  input  logic [PIX_W-1:0] morfologico,
  input  logic [12:0]      H_Cont,
  input  logic [12:0]      V_Cont,
  input  logic [12:0]      V_SYNC_TOTAL,
  output logic [12:0]      x1,
  output logic [12:0]      x2,
  output logic [12:0]      y1,
  output logic [12:0]      y2,
  output logic             ativo,
  output logic [1:0]       win_id,
  output logic             det_pulse
);

  localparam int unsigned CW  = 12;                  // white counter width
  localparam int unsigned LCW = 13;                  // qualifying-line counter width
  localparam int unsigned SEG = H_ACTIVE / NUM_WIN;  // segment width per window

  localparam logic [0:0] S_SEARCH = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0] state_q, state_d;

  logic [NUM_WIN-1:0][12:0]     l_q, l_d;
  logic [NUM_WIN-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [NUM_WIN-1:0][LCW-1:0]  lines_q, lines_d;
  logic [NUM_WIN-1:0]           seen_q, seen_d;
  logic [NUM_WIN-1:0][12:0]     fx_q, fx_d, fy_q, fy_d, lx_q, lx_d;

  logic [12:0] x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
  logic        ativo_q, ativo_d;
  logic [1:0]  win_q, win_d;
  logic        pulse_q, pulse_d;

  // per-window next values assuming the window is actively searching
  logic [NUM_WIN-1:0][12:0]   r_w;
  logic [NUM_WIN-1:0]         in_win, at_left, white_in, eval, qual, det;
  logic [NUM_WIN-1:0][CW-1:0] cbase, cnt_nx;
  logic [NUM_WIN-1:0]         sbase, seen_nx;
  logic [NUM_WIN-1:0][12:0]   fx_nx, fy_nx, lx_nx;

  logic        white;
  logic        frame_end;
  logic        any_det;
  logic [1:0]  sel;
  logic [12:0] bfx, bfy, blx;
  logic signed [13:0] x1s, y1s;
  logic [13:0] x2s, y2s;

`ifdef VERIF_HOLD_EN
  localparam int unsigned HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
  logic [HW-1:0] hold_q, hold_d;
`else
  // hold time only matters with the timed release; nothing is built for it here
  if (HOLD_FRAMES == 0) begin : g_hold_unused
  end
`endif

  assign white     = &morfologico;
  assign frame_end = (V_Cont == V_SYNC_TOTAL) && (H_Cont == 13'd0);

  // Per-window pixel accounting and line evaluation
  always_comb begin
    for (int k = 0; k < NUM_WIN; k++) begin
      r_w[k]      = l_q[k] + 13'(WIN_W - 1);
      in_win[k]   = (H_Cont >= l_q[k]) && (H_Cont <= r_w[k]);
      at_left[k]  = (H_Cont == l_q[k]);
      white_in[k] = in_win[k] && white;
      cbase[k]    = at_left[k] ? '0 : cnt_q[k];
      sbase[k]    = at_left[k] ? 1'b0 : seen_q[k];
      cnt_nx[k]   = cbase[k];
      if (white_in[k] && (cbase[k] != '1)) cnt_nx[k] = cbase[k] + CW'(1);
      seen_nx[k]  = sbase[k] | white_in[k];
      fx_nx[k]    = fx_q[k];
      fy_nx[k]    = fy_q[k];
      lx_nx[k]    = lx_q[k];
      if (white_in[k] && !sbase[k] && (lines_q[k] == '0)) begin
        fx_nx[k] = H_Cont;
        fy_nx[k] = V_Cont;
      end
      if (white_in[k]) lx_nx[k] = H_Cont;
      eval[k] = (H_Cont == r_w[k]);
      qual[k] = (cnt_nx[k] >= CW'(RUN_MIN));
      det[k]  = eval[k] && qual[k] && (lines_q[k] == LCW'(LINES_MIN - 1));
    end
  end

  // Lowest-index detecting window and its padded, clamped box
  always_comb begin
    any_det = |det;
    sel     = 2'd0;
    bfx     = fx_nx[0];
    bfy     = fy_nx[0];
    blx     = lx_nx[0];
    for (int k = int'(NUM_WIN) - 1; k >= 0; k--) begin
      if (det[k]) begin
        sel = 2'(k);
        bfx = fx_nx[k];
        bfy = fy_nx[k];
        blx = lx_nx[k];
      end
    end
    x1s = $signed({1'b0, bfx}) - $signed(14'(MARGIN_X));
    y1s = $signed({1'b0, bfy}) - $signed(14'(MARGIN_Y));
    x2s = {1'b0, blx} + 14'(MARGIN_X);
    y2s = {1'b0, V_Cont} + 14'(MARGIN_Y);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    seen_d  = seen_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    lx_d    = lx_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    ativo_d = ativo_q;
    win_d   = win_q;
    pulse_d = 1'b0;
`ifdef VERIF_HOLD_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      S_SEARCH: begin
        if (!padrao) begin
          cnt_d   = '0;
          lines_d = '0;
          seen_d  = '0;
        end else if (any_det) begin
          state_d = S_LOCKED;
          x1_d    = x1s[13] ? 13'd0 : x1s[12:0];
          y1_d    = y1s[13] ? 13'd0 : y1s[12:0];
          x2_d    = (x2s > 14'(H_ACTIVE - 1)) ? 13'(H_ACTIVE - 1) : x2s[12:0];
          y2_d    = (y2s > 14'(V_ACTIVE - 1)) ? 13'(V_ACTIVE - 1) : y2s[12:0];
          win_d   = sel;
          ativo_d = 1'b1;
          pulse_d = 1'b1;
          cnt_d   = '0;
          lines_d = '0;
          seen_d  = '0;
`ifdef VERIF_HOLD_EN
          hold_d  = '0;
`endif
        end else begin
          cnt_d  = cnt_nx;
          seen_d = seen_nx;
          fx_d   = fx_nx;
          fy_d   = fy_nx;
          lx_d   = lx_nx;
          for (int k = 0; k < NUM_WIN; k++) begin
            if (eval[k]) lines_d[k] = qual[k] ? (lines_q[k] + LCW'(1)) : '0;
            if (frame_end) begin
              if (({1'b0, l_q[k]} + 14'(STEP + WIN_W)) > 14'((k + 1) * SEG))
                l_d[k] = 13'(k * SEG);
              else
                l_d[k] = l_q[k] + 13'(STEP);
            end
          end
        end
      end
      S_LOCKED: begin
        cnt_d   = '0;
        lines_d = '0;
        seen_d  = '0;
`ifdef VERIF_HOLD_EN
        if (frame_end) begin
          if (hold_q == HW'(HOLD_FRAMES - 1)) begin
            state_d = S_SEARCH;
            ativo_d = 1'b0;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
`endif
      end
      default: state_d = S_SEARCH;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_SEARCH;
      for (int k = 0; k < NUM_WIN; k++) l_q[k] <= 13'(k * SEG);
      cnt_q   <= '0;
      lines_q <= '0;
      seen_q  <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      lx_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      ativo_q <= 1'b0;
      win_q   <= '0;
      pulse_q <= 1'b0;
`ifdef VERIF_HOLD_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      seen_q  <= seen_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      lx_q    <= lx_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      ativo_q <= ativo_d;
      win_q   <= win_d;
      pulse_q <= pulse_d;
`ifdef VERIF_HOLD_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign x1        = x1_q;
  assign x2        = x2_q;
  assign y1        = y1_q;
  assign y2        = y2_q;
  assign ativo     = ativo_q;
  assign win_id    = win_q;
  assign det_pulse = pulse_q;

endmodule

// File: tb/tb_pattern_window_detector.sv
// Scoreboard bench for pattern_window_detector (default parameters).
// Only the H positions a window reacts to are driven: its left edge, the white run
// and its right edge. Expected boxes are pushed at the evaluation pixel; a monitor
// pops them whenever det_pulse is seen.
module tb_pattern_window_detector;

  localparam int VST = 624;
  localparam int IDLE_H = 799;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        padrao;
  logic [9:0]  morfologico;
  logic [12:0] H_Cont, V_Cont, V_SYNC_TOTAL;
  logic [12:0] x1, x2, y1, y2;
  logic        ativo;
  logic [1:0]  win_id;
  logic        det_pulse;

  pattern_window_detector dut (
    .Clk(Clk), .Rst(Rst), .padrao(padrao), .morfologico(morfologico),
    .H_Cont(H_Cont), .V_Cont(V_Cont), .V_SYNC_TOTAL(V_SYNC_TOTAL),
    .x1(x1), .x2(x2), .y1(y1), .y2(y2),
    .ativo(ativo), .win_id(win_id), .det_pulse(det_pulse)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          cyc;
    logic [1:0]  win;
    logic [12:0] x1, y1, x2, y2;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every det_pulse must match the oldest expected detection
  always @(negedge Clk) begin
    if (det_pulse === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_det_pulse: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        me = q.pop_front();
        chk("det_cycle", cyc, me.cyc);
        chk("win_id", 32'(win_id), 32'(me.win));
        chk("x1", 32'(x1), 32'(me.x1));
        chk("y1", 32'(y1), 32'(me.y1));
        chk("x2", 32'(x2), 32'(me.x2));
        chk("y2", 32'(y2), 32'(me.y2));
        chk("ativo_at_det", 32'(ativo), 32'd1);
      end
    end
  end

  task automatic drive(input int h, input int v, input logic w);
    H_Cont      = 13'(h);
    V_Cont      = 13'(v);
    morfologico = w ? 10'h3FF : 10'h000;
    @(posedge Clk);
    #1;
  endtask

  task automatic frame_end();
    drive(0, VST, 1'b0);
  endtask

  // one window pass on line v: left edge, white run wlo..whi, right edge
  task automatic seg(input int v, input int l, input int r, input int wlo, input int whi,
                     input bit push, input exp_t e);
    exp_t t;
    drive(l, v, (l >= wlo) && (l <= whi));
    for (int h = wlo; h <= whi; h++)
      if (h != l && h != r) drive(h, v, 1'b1);
    if (push) begin
      t = e;
      t.cyc = cyc + 1;
      q.push_back(t);
    end
    drive(r, v, (r >= wlo) && (r <= whi));
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    padrao = 1'b0;
    H_Cont = 13'(IDLE_H);
    V_Cont = 13'd0;
    morfologico = 10'h000;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic settle_and_drain(input string name);
    drive(IDLE_H, 0, 1'b0);
    drive(IDLE_H, 0, 1'b0);
    chk(name, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  exp_t e_basic, e_win1, e_gap, e_none;

  initial begin
    e_basic = '{0, 2'd0, 13'd5,   13'd90,  13'd234, 13'd164};
    e_win1  = '{0, 2'd1, 13'd405, 13'd90,  13'd634, 13'd164};
    e_gap   = '{0, 2'd0, 13'd0,   13'd132, 13'd219, 13'd206};
    e_none  = '{0, 2'd0, 13'd0,   13'd0,   13'd0,   13'd0};
    V_SYNC_TOTAL = 13'(VST);
    do_reset();

    // reset state
    chk("rst_x1", 32'(x1), 0);
    chk("rst_x2", 32'(x2), 0);
    chk("rst_y1", 32'(y1), 0);
    chk("rst_y2", 32'(y2), 0);
    chk("rst_ativo", 32'(ativo), 0);
    chk("rst_win_id", 32'(win_id), 0);
    chk("rst_det_pulse", 32'(det_pulse), 0);
    chk("rst_L0", 32'(dut.l_q[0]), 0);
    chk("rst_L1", 32'(dut.l_q[1]), 400);

    // window stepping; padrao low freezes the windows
    frame_end();
    chk("freeze_L0", 32'(dut.l_q[0]), 0);
    padrao = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      frame_end();
      chk("step_L0", 32'(dut.l_q[0]), 32'((n % 16) * 10));
      chk("step_L1", 32'(dut.l_q[1]), 32'(400 + (n % 16) * 10));
    end
    do_reset();

    // basic detection in window 0, then hold behaviour
    padrao = 1'b1;
    for (int v = 100; v <= 154; v++) seg(v, 0, 249, 20, 219, v == 154, e_basic);
    settle_and_drain("basic_missing_det");
    chk("basic_ativo", 32'(ativo), 1);
    for (int n = 1; n <= 29; n++) frame_end();
    chk("hold29_ativo", 32'(ativo), 1);
    frame_end();
`ifdef VERIF_HOLD_EN
    chk("hold30_ativo", 32'(ativo), 0);
    chk("hold30_x1_kept", 32'(x1), 5);
    frame_end();
    chk("resume_L0", 32'(dut.l_q[0]), 10);
`else
    chk("locked_ativo", 32'(ativo), 1);
    frame_end();
    chk("locked_L0", 32'(dut.l_q[0]), 0);
`endif
    do_reset();

    // window 1 detection, then asynchronous reset while locked
    padrao = 1'b1;
    for (int v = 100; v <= 154; v++) seg(v, 400, 649, 420, 619, v == 154, e_win1);
    settle_and_drain("win1_missing_det");
    chk("win1_ativo", 32'(ativo), 1);
    #1 Rst = 1'b0;
    #1;
    chk("async_x1", 32'(x1), 0);
    chk("async_x2", 32'(x2), 0);
    chk("async_y1", 32'(y1), 0);
    chk("async_y2", 32'(y2), 0);
    chk("async_ativo", 32'(ativo), 0);
    chk("async_win_id", 32'(win_id), 0);
    do_reset();

    // gap at line 141 restarts the run; box clamps at x = 0
    padrao = 1'b1;
    for (int v = 100; v <= 140; v++) seg(v, 0, 249, 5, 204, 1'b0, e_none);
    seg(141, 0, 249, 1, 0, 1'b0, e_none);
    for (int v = 142; v <= 196; v++) seg(v, 0, 249, 5, 204, v == 196, e_gap);
    settle_and_drain("gap_missing_det");
    do_reset();

    // blocks in both windows: window 0 wins, a single pulse
    padrao = 1'b1;
    for (int v = 100; v <= 154; v++) begin
      seg(v, 0, 249, 20, 219, v == 154, e_basic);
      seg(v, 400, 649, 420, 619, 1'b0, e_none);
    end
    settle_and_drain("dual_missing_det");
    chk("dual_win_id", 32'(win_id), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_window_detector.md
# pattern_window_detector

Parametrised multi-window white-pattern detector for the camera path. It sits after the morphological filter and scans `NUM_WIN` search windows, one per horizontal segment, each stepping across its segment once per frame. It counts white pixels per line in each window and declares a detection once enough consecutive lines qualify. The detection is reported as a margin-padded, clamped bounding box to the overlay/VGA logic, with an optional timed hold.

## Interface
- `NUM_WIN`, 2: number of search windows (1..4); segment width `SEG = H_ACTIVE/NUM_WIN`.
- `PIX_W`, 10: width of `morfologico`.
- `H_ACTIVE`, 800: active pixels per line.
- `V_ACTIVE`, 600: active lines per frame.
- `WIN_W`, 250: window width in pixels; must satisfy `WIN_W <= SEG`.
- `STEP`, 10: window advance per frame, in pixels.
- `RUN_MIN`, 180: white pixels per window-line needed for the line to qualify.
- `LINES_MIN`, 55: consecutive qualifying lines needed for a detection.
- `MARGIN_X`, 15: horizontal box padding.
- `MARGIN_Y`, 10: vertical box padding.
- `HOLD_FRAMES`, 30: detection hold time in frames; used only with `VERIF_HOLD_EN`.
- `Clk` input 1: pixel clock.
- `Rst` input 1: reset, asynchronous, active-low.
- `padrao` input 1: search enable.
- `morfologico` input `PIX_W`: filtered pixel; white when all ones.
- `H_Cont` input 13: horizontal pixel counter.
- `V_Cont` input 13: vertical line counter.
- `V_SYNC_TOTAL` input 13: frame-end line number.
- `x1`, `x2`, `y1`, `y2` output 13: bounding box.
- `ativo` output 1: box valid.
- `win_id` output 2: index of the window that produced the box.
- `det_pulse` output 1: one-cycle strobe when a new box is latched.

## Operation
- Window k has a left edge `L_k`, with reset value `k*SEG`, and a right edge `R_k = L_k + WIN_W - 1`.
- Frame end is the single cycle where `V_Cont == V_SYNC_TOTAL && H_Cont == 0`.
- At frame end, while searching: `L_k <= L_k + STEP`. If `L_k + STEP + WIN_W > (k+1)*SEG`, reload `L_k <= k*SEG` instead.
- Per window, per line:
  - At `H_Cont == L_k`, clear the white counter. The pixel present in that cycle is counted.
  - For `L_k <= H_Cont <= R_k`, each white pixel increments the counter. The counter saturates at 12-bit max.
  - While the line-qualify counter is 0, the first white pixel of the line records `fx_k = H_Cont` and `fy_k = V_Cont`.
  - Every white pixel in the window records `lx_k = H_Cont`.
- Line evaluation happens at `H_Cont == R_k` and includes that cycle's pixel.
  - Line qualifies (count ≥ `RUN_MIN`): `lines_k` increments.
  - Line does not qualify: `lines_k` clears and the recorded `fx_k`/`fy_k` are discarded.
- Detection occurs when `lines_k` reaches `LINES_MIN` at an evaluation point. The box is:
  - `x1 = max(fx_k - MARGIN_X, 0)`
  - `y1 = max(fy_k - MARGIN_Y, 0)`
  - `x2 = min(lx_k + MARGIN_X, H_ACTIVE-1)`
  - `y2 = min(V_Cont + MARGIN_Y, V_ACTIVE-1)`
  - Subtraction uses a 14-bit signed intermediate, so it never wraps.
- If several windows detect in the same cycle, the lowest index wins. The others' `lines_k` clear.
- States are SEARCH and LOCKED.
  - SEARCH → LOCKED on detection: latch the box, set `win_id`, set `ativo = 1`, pulse `det_pulse`, freeze all `L_k`, clear all per-window counters.
  - LOCKED: no evaluation or window stepping; per-window counters hold at 0.
- `padrao = 0` in SEARCH: per-window counters clear and `L_k` freeze. Outputs hold.
- `padrao` has no effect in LOCKED.
- Reset mid-frame returns everything to reset values immediately. Search restarts at the next `H_Cont == L_k`.

## Timing
- Reset values: `x1 = x2 = y1 = y2 = 0`, `ativo = 0`, `win_id = 0`, `det_pulse = 0`, state SEARCH, `L_k = k*SEG`, all counters 0.
- Detection latency: the box, `ativo` and `win_id` update on the clock edge after the evaluation cycle. `det_pulse` is high for exactly that one cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- If frame end and a detection fall in the same cycle, the detection takes priority and `L_k` does not step.

## Configuration
- `VERIF_HOLD_EN` defined:
  - In LOCKED, a frame counter increments at each frame end.
  - On reaching `HOLD_FRAMES`, the block returns to SEARCH from the frozen `L_k`, `ativo` drops to 0, and the box holds its last value.
- `VERIF_HOLD_EN` undefined:
  - LOCKED is terminal until `Rst`, and `ativo` stays 1.
  - The hold counter is not synthesised.

## Test plan
- **Basic detection:** `padrao = 1`, white block at H 20..219, V 100..159, in window 0 with `L_0 = 0`. Required: on line 154 (the 55th qualifying line) `det_pulse`, `win_id = 0`, box (5, 90, 234, 164), `ativo = 1`.
- **Window 1:** same block shifted to H 420..619, `L_1 = 400`. Required: `win_id = 1`, box (405, 90, 634, 164).
- **Gap reset and edge clamp:** white rows V 100..140 and 142..200, block at H 5..204 (window 0). Required: no detection through line 140. The gap at 141 clears `lines_0`, and detection fires at line 196 with `x1 = 0`, `y1 = 132`.
- **Simultaneous detection:** identical blocks in both windows. Required: `win_id = 0` and exactly one `det_pulse`.
- **Window stepping:** `padrao = 1`, all-black frames. Required: `L_0` runs 0, 10, …, 150, then 0 on the 16th frame end. `L_1` runs 400..550, then 400.
- **Hold and mid-lock reset:** with `VERIF_HOLD_EN`, detect, then wait 30 frame ends. Required: `ativo` falls to 0 and search resumes. A separate case asserts `Rst` low in LOCKED. Required: all outputs return to 0 asynchronously.
